// File: rtl/synth_mem_pkg.sv
// Shared definitions for the synth parameter/state RAM arbiter: owner encoding,
// default geometry and the read-return tag.
package synth_mem_pkg;

  localparam logic OWNER_P = 1'b0;
  localparam logic OWNER_A = 1'b1;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/ram_arb_slot.sv
// Two-requester arbiter: P wins by default, A wins when P is idle or once A
// has been denied STARVE_LIMIT consecutive cycles.
module ram_arb_slot #(
  parameter int STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req_p,
  input  logic req_a,
  output logic gnt_p,
  output logic gnt_a,
  output logic sel
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       force_a;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= LIMIT) ? LIMIT : v + 8'd1;
  endfunction

  // Grants are purely combinational so the winner reaches the RAM this cycle.
  always_comb begin
    force_a = req_a && (starve_cnt == LIMIT);
    gnt_a   = !reset && req_a && (!req_p || force_a);
    gnt_p   = !reset && req_p && !force_a;
    sel     = gnt_a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= 8'd0;
    else if (!req_a || gnt_a)
      starve_cnt <= 8'd0;
    else
      starve_cnt <= sat_inc(starve_cnt);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one read port and one write port of the synth RAM between the
// processor (fixed priority) and an auxiliary requester (starvation-protected).
module ram_arbiter
  import synth_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_ren,
  input  logic [ADDR_W-1:0] p_raddr,
  output logic              p_rgnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              p_wen,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_wgnt,
  input  logic              a_ren,
  input  logic [ADDR_W-1:0] a_raddr,
  output logic              a_rgnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              a_wen,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_wgnt,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wen
);

  logic rd_sel, wr_sel, rd_gnt, wr_gnt;

  logic [ADDR_W-1:0] raddr_last, waddr_last;
  logic [DATA_W-1:0] din_last;

  rd_tag_t tag_in;
  rd_tag_t tag_pipe [RD_LAT];

  ram_arb_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_slot (
    .clk   (clk),
    .reset (reset),
    .req_p (p_ren),
    .req_a (a_ren),
    .gnt_p (p_rgnt),
    .gnt_a (a_rgnt),
    .sel   (rd_sel)
  );

  ram_arb_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_slot (
    .clk   (clk),
    .reset (reset),
    .req_p (p_wen),
    .req_a (a_wen),
    .gnt_p (p_wgnt),
    .gnt_a (a_wgnt),
    .sel   (wr_sel)
  );

  // Only a granted requester's fields are routed, so an idle port's X never
  // reaches the RAM; with no winner the last driven value is held.
  always_comb begin
    rd_gnt    = p_rgnt | a_rgnt;
    wr_gnt    = p_wgnt | a_wgnt;
    ram_raddr = raddr_last;
    ram_waddr = waddr_last;
    ram_din   = din_last;
    if (rd_gnt)
      ram_raddr = rd_sel ? a_raddr : p_raddr;
    if (wr_gnt) begin
      ram_waddr = wr_sel ? a_waddr : p_waddr;
      ram_din   = wr_sel ? a_wdata : p_wdata;
    end
    ram_wen = wr_gnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_last <= '0;
      waddr_last <= '0;
      din_last   <= '0;
    end else begin
      raddr_last <= ram_raddr;
      waddr_last <= ram_waddr;
      din_last   <= ram_din;
    end
  end

  always_comb begin
    tag_in.valid = rd_gnt;
    tag_in.owner = rd_sel ? OWNER_A : OWNER_P;
  end

  // Read-return tag pipe: stage 0 is loaded in the grant cycle, the last
  // stage lines up with ram_dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++)
        tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++)
        tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    p_rvalid = tag_pipe[RD_LAT-1].valid && (tag_pipe[RD_LAT-1].owner == OWNER_P);
    a_rvalid = tag_pipe[RD_LAT-1].valid && (tag_pipe[RD_LAT-1].owner == OWNER_A);
    p_rdata  = ram_dout;
    a_rdata  = ram_dout;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM behind the arbiter, a
// directed stimulus process pushing expected reads, and a read-return monitor.
module tb_ram_arbiter;
  import synth_mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Main DUT (RD_LAT=1)
  logic          reset = 1'b1;
  logic          p_ren = 0, p_wen = 0, a_ren = 0, a_wen = 0;
  logic [AW-1:0] p_raddr = 0, p_waddr = 0, a_raddr = 0, a_waddr = 0;
  logic [DW-1:0] p_wdata = 0, a_wdata = 0;
  logic          p_rgnt, p_rvalid, p_wgnt, a_rgnt, a_rvalid, a_wgnt, ram_wen;
  logic [DW-1:0] p_rdata, a_rdata, ram_din;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] mem [256] = '{8'h01: 32'h1111_0001, 8'h02: 32'h2222_0002,
                               8'h03: 32'h3333_0003, 8'h05: 32'h5555_5555,
                               8'h06: 32'h6666_6666, 8'h10: 32'hDEAD_BEEF,
                               default: 32'h0};

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_LIMIT(15)) u_dut (
    .clk(clk), .reset(reset),
    .p_ren(p_ren), .p_raddr(p_raddr), .p_rgnt(p_rgnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .p_wen(p_wen), .p_waddr(p_waddr), .p_wdata(p_wdata), .p_wgnt(p_wgnt),
    .a_ren(a_ren), .a_raddr(a_raddr), .a_rgnt(a_rgnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .a_wen(a_wen), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wgnt(a_wgnt),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout), .ram_waddr(ram_waddr),
    .ram_din(ram_din), .ram_wen(ram_wen)
  );

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  // Second DUT (RD_LAT=2) for the reset-in-flight scenario; writes tied off.
  logic          reset2 = 1'b1;
  logic          p2_ren = 0, a2_ren = 0;
  logic [AW-1:0] p2_raddr = 0, a2_raddr = 0;
  logic          p2_rgnt, p2_rvalid, p2_wgnt, a2_rgnt, a2_rvalid, a2_wgnt, ram2_wen;
  logic [DW-1:0] p2_rdata, a2_rdata, ram2_din;
  logic [AW-1:0] ram2_raddr, ram2_waddr;
  logic [DW-1:0] ram2_q1 = '0, ram2_dout = '0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_LIMIT(15)) u_dut2 (
    .clk(clk), .reset(reset2),
    .p_ren(p2_ren), .p_raddr(p2_raddr), .p_rgnt(p2_rgnt), .p_rvalid(p2_rvalid), .p_rdata(p2_rdata),
    .p_wen(1'b0), .p_waddr(8'h00), .p_wdata(32'h0), .p_wgnt(p2_wgnt),
    .a_ren(a2_ren), .a_raddr(a2_raddr), .a_rgnt(a2_rgnt), .a_rvalid(a2_rvalid), .a_rdata(a2_rdata),
    .a_wen(1'b0), .a_waddr(8'h00), .a_wdata(32'h0), .a_wgnt(a2_wgnt),
    .ram_raddr(ram2_raddr), .ram_dout(ram2_dout), .ram_waddr(ram2_waddr),
    .ram_din(ram2_din), .ram_wen(ram2_wen)
  );

  always @(posedge clk) begin
    ram2_q1   <= {24'h0, ram2_raddr};
    ram2_dout <= ram2_q1;
  end

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   a_win;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_rd(input logic owner, input logic [DW-1:0] d);
    sb_q.push_back('{owner: owner, data: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor
  always @(negedge clk) begin
    if (!reset && (p_rvalid || a_rvalid)) begin
      if (sb_q.size() == 0) begin
        chk("rd_unexpected", {p_rvalid, a_rvalid}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        chk("rd_owner", {p_rvalid, a_rvalid}, (e.owner == OWNER_A) ? 2'b01 : 2'b10);
        chk("rd_data", p_rvalid ? p_rdata : a_rdata, e.data);
      end
    end
  end

  initial begin
    // Reset, idle requests
    repeat (2) @(negedge clk);
    chk("rst_p_rgnt", p_rgnt, 0);
    chk("rst_a_rgnt", a_rgnt, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    chk("rst_ram_waddr", ram_waddr, 0);
    chk("rst_ram_din", ram_din, 0);
    p_ren = 1; a_wen = 1;
    #1;
    chk("rst_force_p_rgnt", p_rgnt, 0);
    chk("rst_force_a_wgnt", a_wgnt, 0);
    chk("rst_force_ram_wen", ram_wen, 0);
    p_ren = 0; a_wen = 0;
    tick();
    reset = 0;

    // Single P read
    p_ren = 1; p_raddr = 8'h10;
    expect_rd(OWNER_P, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("p1_rgnt", p_rgnt, 1);
    chk("p1_a_rgnt", a_rgnt, 0);
    chk("p1_ram_raddr", ram_raddr, 8'h10);
    tick();
    p_ren = 0;
    @(negedge clk);
    chk("p1_rvalid_lat", p_rvalid, 1);
    chk("p1_a_rvalid", a_rvalid, 0);
    chk("idle_raddr_hold", ram_raddr, 8'h10);
    tick();

    // Continuous contention: A forced through every 16th cycle
    p_ren = 1; p_raddr = 8'h05; a_ren = 1; a_raddr = 8'h06;
    for (int c = 0; c < 32; c++) begin
      a_win = ((c % 16) == 15);
      if (a_win) expect_rd(OWNER_A, 32'h6666_6666);
      else       expect_rd(OWNER_P, 32'h5555_5555);
      @(negedge clk);
      chk("starve_p_rgnt", p_rgnt, !a_win);
      chk("starve_a_rgnt", a_rgnt, a_win);
      tick();
    end
    p_ren = 0; a_ren = 0;
    tick();

    // Interleaved owners on consecutive cycles
    p_ren = 1; p_raddr = 8'h01; expect_rd(OWNER_P, 32'h1111_0001);
    @(negedge clk); chk("il_p1_rgnt", p_rgnt, 1);
    tick();
    p_ren = 0; a_ren = 1; a_raddr = 8'h02; expect_rd(OWNER_A, 32'h2222_0002);
    @(negedge clk); chk("il_a2_rgnt", a_rgnt, 1);
    tick();
    a_ren = 0; p_ren = 1; p_raddr = 8'h03; expect_rd(OWNER_P, 32'h3333_0003);
    @(negedge clk); chk("il_p3_rgnt", p_rgnt, 1);
    tick();
    p_ren = 0;
    @(negedge clk); chk("il_p3_rvalid", p_rvalid, 1);
    tick();

    // Simultaneous writes: P commits first, A the next cycle
    p_wen = 1; p_waddr = 8'h20; p_wdata = 32'h1111_1111;
    a_wen = 1; a_waddr = 8'h21; a_wdata = 32'h2222_2222;
    @(negedge clk);
    chk("w1_p_wgnt", p_wgnt, 1);
    chk("w1_a_wgnt", a_wgnt, 0);
    chk("w1_ram_wen", ram_wen, 1);
    chk("w1_ram_waddr", ram_waddr, 8'h20);
    chk("w1_ram_din", ram_din, 32'h1111_1111);
    tick();
    p_wen = 0;
    @(negedge clk);
    chk("w2_a_wgnt", a_wgnt, 1);
    chk("w2_p_wgnt", p_wgnt, 0);
    chk("w2_ram_waddr", ram_waddr, 8'h21);
    chk("w2_ram_din", ram_din, 32'h2222_2222);
    tick();
    a_wen = 0;
    p_ren = 1; p_raddr = 8'h20; expect_rd(OWNER_P, 32'h1111_1111);
    @(negedge clk);
    chk("w3_ram_wen", ram_wen, 0);
    chk("w3_waddr_hold", ram_waddr, 8'h21);
    chk("w3_din_hold", ram_din, 32'h2222_2222);
    tick();
    p_ren = 0; a_ren = 1; a_raddr = 8'h21; expect_rd(OWNER_A, 32'h2222_2222);
    tick();
    a_ren = 0;
    tick();

    // Same-cycle read and write of one address returns old data
    p_wen = 1; p_waddr = 8'h30; p_wdata = 32'h0000_ABCD;
    a_ren = 1; a_raddr = 8'h30; expect_rd(OWNER_A, 32'h0);
    @(negedge clk);
    chk("rw_p_wgnt", p_wgnt, 1);
    chk("rw_a_rgnt", a_rgnt, 1);
    tick();
    p_wen = 0; a_ren = 0;
    p_ren = 1; p_raddr = 8'h30; expect_rd(OWNER_P, 32'h0000_ABCD);
    tick();
    p_ren = 0;
    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 0);

    // Reset while an A read is in flight (RD_LAT=2)
    reset2 = 0;
    a2_ren = 1; a2_raddr = 8'h06;
    @(negedge clk);
    chk("rf_a_rgnt", a2_rgnt, 1);
    tick();
    p2_ren = 1; a2_ren = 1;
    reset2 = 1;
    #2;
    chk("rf_rst_p_rgnt", p2_rgnt, 0);
    chk("rf_rst_a_rgnt", a2_rgnt, 0);
    chk("rf_rst_raddr", ram2_raddr, 0);
    reset2 = 0; p2_ren = 0; a2_ren = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rf_no_a_rvalid", a2_rvalid, 0);
      chk("rf_no_p_rvalid", p2_rvalid, 0);
      tick();
    end

    // Starvation count is cleared by reset
    p2_ren = 1; a2_ren = 1; p2_raddr = 8'h05;
    repeat (8) tick();
    reset2 = 1;
    #2;
    reset2 = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("rst_cnt_a_rgnt", a2_rgnt, c == 15);
      chk("rst_cnt_p_rgnt", p2_rgnt, c != 15);
      tick();
    end
    p2_ren = 0; a2_ren = 0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single synth parameter/state RAM (one read port, one write port, 256 x 32) between two requesters: the processor (P) and an auxiliary requester (A), e.g. a preset load/save engine or a UI readback.
- P has fixed priority, so the sample-path timing is unchanged.
- A is guaranteed progress through a per-port starvation counter.
- Sits between the processor/aux blocks and the RAM instance.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 32, RAM data width
- RD_LAT, 1, RAM read latency in clk cycles (ram_raddr registered to ram_dout valid); legal range 1..3
- STARVE_LIMIT, 15, consecutive denied A cycles before A is forced to win; legal range 1..255

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- p_ren  in  1  P read request
- p_raddr  in  ADDR_W  P read address
- p_rgnt  out  1  P read granted this cycle
- p_rvalid  out  1  p_rdata holds P's data
- p_rdata  out  DATA_W  read data to P
- p_wen  in  1  P write request
- p_waddr  in  ADDR_W  P write address
- p_wdata  in  DATA_W  P write data
- p_wgnt  out  1  P write granted (committed) this cycle
- a_ren, a_raddr, a_rgnt, a_rvalid, a_rdata  same as the P read signals, for A
- a_wen, a_waddr, a_wdata, a_wgnt  same as the P write signals, for A
- ram_raddr  out  ADDR_W  to RAM
- ram_dout  in  DATA_W  from RAM
- ram_waddr  out  ADDR_W  to RAM
- ram_din  out  DATA_W  to RAM
- ram_wen  out  1  to RAM

Behaviour:
- Read and write ports are arbitrated independently, each by an identical slot; the rules below apply per slot.
- Grant is combinational, in the same cycle as the request.
- Default winner is P whenever P requests.
- A wins when A requests and P does not.
- A also wins when A requests and the slot's starve_cnt == STARVE_LIMIT; P is then denied for that one cycle.
  - P must hold its request until granted.
  - The processor controller already waits on a grant.
- A loser sees gnt=0 and must hold its address and data stable until granted.
- starve_cnt (8-bit register) per slot:
  - clears when A is granted or A is not requesting;
  - increments, saturating at STARVE_LIMIT, when A requests and is denied.
- RAM muxing:
  - ram_raddr and ram_waddr/ram_din carry the winner's values.
  - With no winner they hold the last driven value; they are 0 after reset.
  - ram_wen = p_wgnt | a_wgnt.
- Read return:
  - An RD_LAT-deep shift register of {valid, owner} tags.
  - The tag is pushed on every cycle in which a read grant is issued.
  - At the tag output, p_rvalid or a_rvalid pulses for exactly 1 cycle.
  - p_rdata and a_rdata both equal ram_dout; only the matching rvalid qualifies the data.
- Back-to-back reads from any mix of owners are accepted every cycle; throughput is 1 read plus 1 write per cycle.
- Read and write to the same address in the same cycle: the arbiter does not forward. The RAM's read-during-write (old data) is returned, and the bench checks old data.
- Reset, asynchronous:
  - all grants are forced to 0 while reset is high;
  - ram_wen = 0, valids = 0, tag pipe cleared, starve_cnt = 0, ram_raddr/ram_waddr/ram_din = 0.
- Reset mid-read: in-flight tags are discarded; no rvalid is issued after reset deasserts.
- First grant is possible on the first clk edge after reset deassertion.
- X on an unrequested port's address or data must not propagate to the RAM outputs.

Decomposition:
- Shared package synth_mem_pkg:
  - OWNER_P = 1'b0, OWNER_A = 1'b1;
  - default ADDR_W and DATA_W;
  - the read-tag struct/typedef {valid, owner}.
- One sub-module, ram_arb_slot: 2-requester priority arbiter with starvation counter, producing gnt_p, gnt_a and sel. It is instantiated twice, once for the read port and once for the write port.
- Top level holds the data muxes and the read-tag pipeline.

Test Plan:
- Reset with all requests idle -> all outputs 0. Then p_ren=1, p_raddr=0x10, with RAM preloaded 0x10=0xDEADBEEF -> p_rgnt=1 same cycle; p_rvalid=1 and p_rdata=0xDEADBEEF after RD_LAT=1 cycle; a_rvalid stays 0.
- p_ren and a_ren held high continuously, STARVE_LIMIT=15 -> P granted for 15 cycles, A granted on the 16th, starve_cnt returns to 0. Pattern repeats every 16 cycles.
- Interleaved reads P@0x01, A@0x02, P@0x03 on consecutive cycles -> rvalid pulses arrive in order with correct owners and data; no bubbles.
- Simultaneous p_wen (0x20, 0x11111111) and a_wen (0x21, 0x22222222) -> P write commits first. A write commits the next cycle with a_wgnt=1. Readback gives both values.
- Same-cycle write 0x30=0xABCD and read 0x30 (old value 0x0) -> returned data 0x0; the next read returns 0xABCD.
- Assert reset while an A read is in flight (RD_LAT=2) -> no a_rvalid after release; all grants 0 during reset; starve_cnt reads 0.
